// File: rtl/dsky_key_input_pkg.sv
// Shared encodings for the DSKY keyboard front end: debounce states, null key, channel 15 word layout.
// DSKY_PARITY_EN (optional define) puts odd parity over the whole word into channel 15 bit 15.
package dsky_key_input_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam logic [4:0] KEY_NONE  = 5'd0;
    localparam int         KEY_W     = 5;
    localparam int         CHAN_W    = 16;
    localparam int         PAR_BIT   = 15;

    function automatic logic [CHAN_W-1:0] chan_word(input logic [KEY_W-1:0] key);
        logic [CHAN_W-1:0] w;
        w = '0;
        w[KEY_W-1:0] = key;
`ifdef DSKY_PARITY_EN
        // Bits 14:5 are zero, so the keycode alone decides the parity bit.
        w[PAR_BIT] = ~^key;
`endif
        return w;
    endfunction

endpackage

// File: rtl/dsky_key_input_if.sv
// Keyboard/CPU side bundle of the DSKY key front end: raw keycode in, channel 15 + KEYRUPT out.
// master = keyboard matrix + CPU side, slave = dsky_key_input.
import dsky_key_input_pkg::*;

interface dsky_key_input_if;
    logic [KEY_W-1:0]  key_code;
    logic              chan_rd;
    logic [CHAN_W-1:0] chan_data;
    logic              keyrupt;
    logic              rupt_ack;
    logic [4:0]        fifo_count;
    logic              overflow;
    logic              ovf_clr;

    modport master (
        output key_code, chan_rd, rupt_ack, ovf_clr,
        input  chan_data, keyrupt, fifo_count, overflow
    );

    modport slave (
        input  key_code, chan_rd, rupt_ack, ovf_clr,
        output chan_data, keyrupt, fifo_count, overflow
    );
endinterface

// File: rtl/dsky_key_fifo.sv
// Circular keycode queue with sticky overflow; zero latency (head/count valid right after the write/pop edge).
// Push when full is dropped and flags overflow unless a pop frees the slot in the same cycle; pop when empty is ignored.
import dsky_key_input_pkg::*;

module dsky_key_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [KEY_W-1:0] push_dat,
    input  logic             pop,
    input  logic             ovf_clr,
    output logic [KEY_W-1:0] head_dat,
    output logic [4:0]       count,
    output logic             empty,
    output logic             overflow
);
    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [4:0] FULL_CNT = 5'(FIFO_DEPTH);

    logic [KEY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;
    logic             ovf_set;

    assign empty    = (count == 5'd0);
    assign full     = (count == FULL_CNT);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign ovf_set  = push && full && !pop_ok;
    assign head_dat = empty ? KEY_NONE : mem[rd_ptr];

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/dsky_key_input.sv
// DSKY keyboard front end: debounce raw keycodes, queue them, present channel 15 with KEYRUPT.
// Push lands DEBOUNCE_CYCLES-1 edges after a stable key is first sampled; keyrupt follows one edge later.
// Full queue drops keys (sticky overflow); KEYRUPT re-arms on each channel 15 read. Option: DSKY_PARITY_EN.
import dsky_key_input_pkg::*;

module dsky_key_input #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    dsky_key_input_if.slave bus
);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    deb_state_t       state;
    logic [KEY_W-1:0] cand;
    logic [7:0]       cnt;
    logic             push;
    logic             keyrupt_q;
    logic             armed;
    logic [KEY_W-1:0] head_dat;
    logic             empty;

    // The accepting cycle is the one whose sample brings the count to DEBOUNCE_CYCLES.
    assign push = (state == PRESS_WAIT) && (bus.key_code == cand) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cand  <= KEY_NONE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.key_code != KEY_NONE) begin
                        state <= PRESS_WAIT;
                        cand  <= bus.key_code;
                        cnt   <= 8'd1;
                    end
                end
                PRESS_WAIT: begin
                    if (bus.key_code == KEY_NONE) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (bus.key_code != cand) begin
                        cand <= bus.key_code;
                        cnt  <= 8'd1;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HELD: begin
                    if (bus.key_code == KEY_NONE) begin
                        state <= RELEASE_WAIT;
                        cnt   <= 8'd1;
                    end
                end
                RELEASE_WAIT: begin
                    if (bus.key_code != KEY_NONE) begin
                        state <= HELD;
                        cnt   <= 8'd0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A read in the same cycle as an ack re-arms, so a pending key is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            keyrupt_q <= 1'b0;
            armed     <= 1'b1;
        end else begin
            if (bus.chan_rd)       armed <= 1'b1;
            else if (bus.rupt_ack) armed <= 1'b0;
            keyrupt_q <= !bus.rupt_ack && armed && !empty;
        end
    end

    dsky_key_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (cand),
        .pop      (bus.chan_rd),
        .ovf_clr  (bus.ovf_clr),
        .head_dat (head_dat),
        .count    (bus.fifo_count),
        .empty    (empty),
        .overflow (bus.overflow)
    );

    assign bus.chan_data = chan_word(head_dat);
    assign bus.keyrupt   = keyrupt_q;

endmodule
